// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit.
// Fixed 33-cycle latency from accepted start to done pulse.
module muldiv_unit #(
  parameter int DataWidth = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2:0]           func,
  input  logic [DataWidth-1:0] op1,
  input  logic [DataWidth-1:0] op2,
  output logic                 busy,
  output logic                 done,
  output logic [DataWidth-1:0] result
);

  localparam int W = DataWidth;

  localparam logic [2:0] F_MUL    = 3'd0;
  localparam logic [2:0] F_MULH   = 3'd1;
  localparam logic [2:0] F_MULHSU = 3'd2;
  localparam logic [2:0] F_MULHU  = 3'd3;
  localparam logic [2:0] F_DIV    = 3'd4;
  localparam logic [2:0] F_DIVU   = 3'd5;
  localparam logic [2:0] F_REM    = 3'd6;
  localparam logic [2:0] F_REMU   = 3'd7;

  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] ALL_ONE = {W{1'b1}};

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [2:0]     fn;
  logic [W-1:0]   ma;
  logic [W-1:0]   mb;
  logic [2*W-1:0] acc;
  logic [W:0]     rem;
  logic [W-1:0]   quo;
  logic           neg_q;
  logic           neg_r;
  logic           divz;
  logic           ovf;
  logic [5:0]     cnt;

  logic           accept;
  logic           last;
  logic           sa_in;
  logic           sb_in;
  logic           na_in;
  logic           nb_in;
  logic [W-1:0]   ma_in;
  logic [W-1:0]   mb_in;

  logic [W:0]     psum;
  logic [2*W-1:0] acc_nxt;
  logic [W+1:0]   dsub;
  logic           ge;
  logic [W:0]     rem_nxt;
  logic [W-1:0]   quo_nxt;
  logic [2*W-1:0] prod;
  logic [W-1:0]   q_fix;
  logic [W-1:0]   r_fix;
  logic [W-1:0]   res_nxt;

  assign accept = start && (state != CALC);
  assign last   = (state == CALC) && (cnt == 6'd1);

  // Operand signedness per funct3 and magnitude conversion at latch time.
  always_comb begin
    sa_in = 1'b0;
    sb_in = 1'b0;
    unique case (func)
      F_MUL, F_MULH,
      F_DIV, F_REM: begin
        sa_in = 1'b1;
        sb_in = 1'b1;
      end
      F_MULHSU: sa_in = 1'b1;
      default: begin
        sa_in = 1'b0;
        sb_in = 1'b0;
      end
    endcase
    na_in = sa_in & op1[W-1];
    nb_in = sb_in & op2[W-1];
    ma_in = na_in ? -op1 : op1;
    mb_in = nb_in ? -op2 : op2;
  end

  // One shift-add and one restoring-divide step per cycle.
  always_comb begin
    psum    = {1'b0, acc[2*W-1:W]}
            + (acc[0] ? {1'b0, ma} : '0);
    acc_nxt = {psum, acc[W-1:1]};
    dsub    = {rem, quo[W-1]} - {2'b00, mb};
    ge      = ~dsub[W+1];
    rem_nxt = ge ? dsub[W:0]
                 : {rem[W-1:0], quo[W-1]};
    quo_nxt = {quo[W-2:0], ge};
  end

  // Sign fix-up and special-case overrides on the final step.
  // A zero divisor leaves the dividend as remainder on its own.
  always_comb begin
    prod    = neg_q ? -acc_nxt : acc_nxt;
    q_fix   = neg_q ? -quo_nxt : quo_nxt;
    r_fix   = neg_r ? -rem_nxt[W-1:0]
                    : rem_nxt[W-1:0];
    res_nxt = '0;
    unique case (fn)
      F_MUL:
        res_nxt = prod[W-1:0];
      F_MULH, F_MULHSU, F_MULHU:
        res_nxt = prod[2*W-1:W];
      F_DIV, F_DIVU: begin
        if (divz)
          res_nxt = ALL_ONE;
        else if (ovf)
          res_nxt = MIN_NEG;
        else
          res_nxt = q_fix;
      end
      F_REM, F_REMU: begin
        if (ovf && !divz)
          res_nxt = '0;
        else
          res_nxt = r_fix;
      end
      default: res_nxt = '0;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Next-state and status outputs.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        state_nxt = start ? CALC : IDLE;
      end
      CALC: begin
        busy = 1'b1;
        if (cnt == 6'd1)
          state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = start ? CALC : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand latch, iteration registers and result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      fn     <= '0;
      ma     <= '0;
      mb     <= '0;
      acc    <= '0;
      rem    <= '0;
      quo    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      divz   <= 1'b0;
      ovf    <= 1'b0;
      cnt    <= '0;
      result <= '0;
    end else if (accept) begin
      fn    <= func;
      ma    <= ma_in;
      mb    <= mb_in;
      acc   <= {{W{1'b0}}, mb_in};
      rem   <= '0;
      quo   <= ma_in;
      neg_q <= na_in ^ nb_in;
      neg_r <= na_in;
      divz  <= (op2 == '0);
      ovf   <= sa_in && sb_in
            && (op1 == MIN_NEG)
            && (op2 == ALL_ONE);
      cnt   <= 6'd32;
    end else if (state == CALC) begin
      cnt <= cnt - 6'd1;
      acc <= acc_nxt;
      rem <= rem_nxt;
      quo <= quo_nxt;
      if (last)
        result <= res_nxt;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed checks for muldiv_unit.
// Latency, results, special cases, handshake and reset.
module tb_muldiv_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  func;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int pass_cnt = 0;
  int total_cnt = 0;

  muldiv_unit #(.DataWidth(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .func   (func),
    .op1    (op1),
    .op2    (op2),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one op at cycle T, observe T+1..T+33.
  // Operands are scrambled after the start cycle.
  task automatic run_op(
    input  logic [2:0]  f,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] r,
    output int          nbusy,
    output int          nearly,
    output logic        d33,
    output logic        b33
  );
    @(negedge clk);
    start = 1'b1; func = f; op1 = a; op2 = b;
    nbusy = 0;
    nearly = 0;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      start = 1'b0;
      op1 = ~a; op2 = ~b; func = ~f;
      if (busy === 1'b1) nbusy++;
      if (done !== 1'b0) nearly++;
    end
    @(negedge clk);
    d33 = done;
    b33 = busy;
    r = result;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0;
    func = '0; op1 = '0; op2 = '0;
    repeat (3) @(negedge clk);
    total_cnt++;
    if (busy !== 1'b0)
      $display("FAIL reset_busy got %b want 0", busy);
    else pass_cnt++;
    total_cnt++;
    if (done !== 1'b0)
      $display("FAIL reset_done got %b want 0", done);
    else pass_cnt++;
    total_cnt++;
    if (result !== 32'h0)
      $display("FAIL reset_result got %h want 0", result);
    else pass_cnt++;
    rst = 1'b0;
  endtask

  // Table-driven ops; each checks value and full latency.
  task automatic test_ops;
    logic [2:0]  tf [14];
    logic [31:0] ta [14];
    logic [31:0] tb [14];
    logic [31:0] te [14];
    logic [31:0] r;
    int nb, ne;
    logic d33, b33;
    tf[0]=3'd0;  ta[0]=32'd7;         tb[0]=32'hFFFFFFFD; te[0]=32'hFFFFFFEB;
    tf[1]=3'd3;  ta[1]=32'hFFFFFFFF;  tb[1]=32'hFFFFFFFF; te[1]=32'hFFFFFFFE;
    tf[2]=3'd1;  ta[2]=32'h80000000;  tb[2]=32'h80000000; te[2]=32'h40000000;
    tf[3]=3'd2;  ta[3]=32'hFFFFFFFF;  tb[3]=32'hFFFFFFFF; te[3]=32'hFFFFFFFF;
    tf[4]=3'd4;  ta[4]=32'hFFFFFFF9;  tb[4]=32'd2;        te[4]=32'hFFFFFFFD;
    tf[5]=3'd6;  ta[5]=32'hFFFFFFF9;  tb[5]=32'd2;        te[5]=32'hFFFFFFFF;
    tf[6]=3'd5;  ta[6]=32'd100;       tb[6]=32'd7;        te[6]=32'd14;
    tf[7]=3'd7;  ta[7]=32'd100;       tb[7]=32'd7;        te[7]=32'd2;
    tf[8]=3'd5;  ta[8]=32'd5;         tb[8]=32'd0;        te[8]=32'hFFFFFFFF;
    tf[9]=3'd6;  ta[9]=32'd5;         tb[9]=32'd0;        te[9]=32'd5;
    tf[10]=3'd4; ta[10]=32'h80000000; tb[10]=32'hFFFFFFFF; te[10]=32'h80000000;
    tf[11]=3'd6; ta[11]=32'h80000000; tb[11]=32'hFFFFFFFF; te[11]=32'h0;
    tf[12]=3'd4; ta[12]=32'hFFFFFFF9; tb[12]=32'd0;       te[12]=32'hFFFFFFFF;
    tf[13]=3'd6; ta[13]=32'hFFFFFFF9; tb[13]=32'd0;       te[13]=32'hFFFFFFF9;
    for (int i = 0; i < 14; i++) begin
      run_op(tf[i], ta[i], tb[i], r, nb, ne, d33, b33);
      total_cnt++;
      if (r !== te[i])
        $display("FAIL op%0d_result got %h want %h", i, r, te[i]);
      else pass_cnt++;
      total_cnt++;
      if (nb != 32)
        $display("FAIL op%0d_busy_cycles got %0d want 32", i, nb);
      else pass_cnt++;
      total_cnt++;
      if (ne != 0 || d33 !== 1'b1)
        $display("FAIL op%0d_done early=%0d d33=%b want 0/1", i, ne, d33);
      else pass_cnt++;
      total_cnt++;
      if (b33 !== 1'b0)
        $display("FAIL op%0d_busy_t33 got %b want 0", i, b33);
      else pass_cnt++;
    end
  endtask

  // Ignored start while busy, then zero-bubble restart.
  task automatic test_back_to_back;
    int bad_busy = 0;
    int bad_hold = 0;
    @(negedge clk);
    start = 1'b1; func = 3'd5; op1 = 32'd9; op2 = 32'd3;
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 5) begin
        start = 1'b1; func = 3'd5; op1 = 32'd8; op2 = 32'd2;
      end
      if (k <= 32 && busy !== 1'b1) bad_busy++;
    end
    total_cnt++;
    if (done !== 1'b1 || result !== 32'd3)
      $display("FAIL b2b_first got done=%b res=%h want 1/3", done, result);
    else pass_cnt++;
    start = 1'b1; func = 3'd5; op1 = 32'd8; op2 = 32'd2;
    for (int k = 34; k <= 65; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy !== 1'b1) bad_busy++;
      if (done !== 1'b0 || result !== 32'd3) bad_hold++;
    end
    @(negedge clk);
    total_cnt++;
    if (done !== 1'b1 || result !== 32'd4)
      $display("FAIL b2b_second got done=%b res=%h want 1/4", done, result);
    else pass_cnt++;
    total_cnt++;
    if (bad_busy != 0)
      $display("FAIL b2b_busy got %0d bad cycles want 0", bad_busy);
    else pass_cnt++;
    total_cnt++;
    if (bad_hold != 0)
      $display("FAIL b2b_hold got %0d bad cycles want 0", bad_hold);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (done !== 1'b0 || busy !== 1'b0 || result !== 32'd4)
      $display("FAIL b2b_after got d=%b b=%b r=%h want 0/0/4", done, busy, result);
    else pass_cnt++;
  endtask

  // Abort mid-operation; then reset together with start.
  task automatic test_reset_abort;
    int ndone = 0;
    int nbusy = 0;
    logic [31:0] r;
    int nb, ne;
    logic d33, b33;
    @(negedge clk);
    start = 1'b1; func = 3'd0; op1 = 32'd3; op2 = 32'd4;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 10) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    total_cnt++;
    if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL abort_state got b=%b d=%b want 0/0", busy, done);
    else pass_cnt++;
    total_cnt++;
    if (result !== 32'h0)
      $display("FAIL abort_result got %h want 0", result);
    else pass_cnt++;
    repeat (40) begin
      @(negedge clk);
      if (done !== 1'b0) ndone++;
      if (busy !== 1'b0) nbusy++;
    end
    total_cnt++;
    if (ndone != 0 || nbusy != 0)
      $display("FAIL abort_quiet got done=%0d busy=%0d want 0/0", ndone, nbusy);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b1; start = 1'b1;
    func = 3'd0; op1 = 32'd3; op2 = 32'd4;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    ndone = 0;
    nbusy = 0;
    total_cnt++;
    if (busy !== 1'b0)
      $display("FAIL rst_start_busy got %b want 0", busy);
    else pass_cnt++;
    repeat (40) begin
      @(negedge clk);
      if (done !== 1'b0) ndone++;
      if (busy !== 1'b0) nbusy++;
    end
    total_cnt++;
    if (ndone != 0 || nbusy != 0 || result !== 32'h0)
      $display("FAIL rst_start_idle got d=%0d b=%0d r=%h want 0/0/0", ndone, nbusy, result);
    else pass_cnt++;
    run_op(3'd0, 32'd3, 32'd4, r, nb, ne, d33, b33);
    total_cnt++;
    if (r !== 32'd12 || nb != 32 || d33 !== 1'b1)
      $display("FAIL post_reset_mul got r=%h busy=%0d d=%b want c/32/1", r, nb, d33);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_ops();
    test_back_to_back();
    test_reset_abort();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
